// File: rtl/fp32_pkg.sv
// Shared definitions for the fp32 conversion and arithmetic blocks:
// converter FSM states, IEEE 754 single-precision field positions and constants.
package fp32_pkg;

  localparam int EXP_BIAS = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  localparam logic [31:0] FP32_POS_ZERO = 32'h00000000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } conv_state_t;

endpackage

// File: rtl/fp32_round_rne.sv
// Round-to-nearest-even on a 23-bit mantissa with guard/sticky bits.
// A mantissa carry-out is folded into the exponent.
module fp32_round_rne
  import fp32_pkg::*;
(
  input  logic [MANT_MSB:0]        mant,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic [EXP_MSB-EXP_LSB:0] exp,
  output logic [MANT_MSB:0]        mant_out,
  output logic [EXP_MSB-EXP_LSB:0] exp_out,
  output logic                     inexact
);

  logic              round_up;
  logic [MANT_MSB+1:0] mant_sum;

  // Ties go up only when that makes the mantissa even.
  assign round_up = guard & (sticky | mant[0]);
  assign mant_sum = {1'b0, mant} + {{(MANT_MSB+1){1'b0}}, round_up};

  // On carry the low 23 bits are already zero, i.e. 1.0 x 2^(exp+1).
  assign mant_out = mant_sum[MANT_MSB:0];
  assign exp_out  = exp + {{(EXP_MSB-EXP_LSB){1'b0}}, mant_sum[MANT_MSB+1]};
  assign inexact  = guard | sticky;

endmodule

// File: rtl/int_to_fp32.sv
// Multi-cycle 32-bit integer (signed or unsigned) to IEEE 754 single converter.
// Normalises one bit per cycle, then rounds to nearest even.
module int_to_fp32 #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Input side is ready only in IDLE; output is valid only in DONE and the
  // result stays stable until out_ready is seen.

  fp32_pkg::conv_state_t state_q, state_d;

  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic [31:0] out_data_q;
  logic        out_inexact_q;

  logic [31:0] mag_in;
  logic [22:0] rnd_mant;
  logic [7:0]  rnd_exp;
  logic        rnd_inexact;

  assign mag_in = (in_signed & in_data[31]) ? (~in_data + 32'd1) : in_data;

  fp32_round_rne u_round (
    .mant     (mag_q[30:8]),
    .guard    (mag_q[7]),
    .sticky   (|mag_q[6:0]),
    .exp      (exp_q),
    .mant_out (rnd_mant),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= fp32_pkg::IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      fp32_pkg::IDLE:  if (in_valid) state_d = (in_data == 32'd0) ? fp32_pkg::DONE : fp32_pkg::NORM;
      fp32_pkg::NORM:  if (mag_q[31]) state_d = fp32_pkg::ROUND;
      fp32_pkg::ROUND: state_d = fp32_pkg::DONE;
      fp32_pkg::DONE:  if (out_ready) state_d = fp32_pkg::IDLE;
      default:         state_d = fp32_pkg::IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q        <= 1'b0;
      mag_q         <= 32'd0;
      exp_q         <= 8'd0;
      out_data_q    <= fp32_pkg::FP32_POS_ZERO;
      out_inexact_q <= 1'b0;
    end else begin
      case (state_q)
        fp32_pkg::IDLE: begin
          if (in_valid) begin
            sign_q <= in_signed & in_data[31];
            mag_q  <= mag_in;
            exp_q  <= 8'(EXP_BIAS + 31);
            // Zero skips normalisation; always +0, even for signed input.
            if (in_data == 32'd0) begin
              out_data_q    <= fp32_pkg::FP32_POS_ZERO;
              out_inexact_q <= 1'b0;
            end
          end
        end
        fp32_pkg::NORM: begin
          if (!mag_q[31]) begin
            mag_q <= {mag_q[30:0], 1'b0};
            exp_q <= exp_q - 8'd1;
          end
        end
        fp32_pkg::ROUND: begin
          out_data_q    <= {sign_q, rnd_exp, rnd_mant};
          out_inexact_q <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == fp32_pkg::IDLE);
  assign out_valid   = (state_q == fp32_pkg::DONE);
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: doc/int_to_fp32.md
Name: int_to_fp32

Overview:
Multi-cycle converter from a 32-bit two's-complement or unsigned integer to IEEE 754 single precision (sign [31], exponent [30:23], mantissa [22:0]). It produces operands in the format the floating-point ALU consumes, so integer sources can feed the add, multiply and divide paths. Operands arrive through a valid/ready input handshake. Normalisation is iterative, one bit per cycle. Rounding is round-to-nearest-even. Results leave through a valid/ready output handshake.

Parameters:
EXP_BIAS, 127, single-precision exponent bias; only 127 is supported.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  operand offered
in_ready  output  1  converter can accept an operand
in_data  input  32  integer operand
in_signed  input  1  1 = in_data is two's complement, 0 = unsigned
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  32  IEEE 754 single-precision result
out_inexact  output  1  rounding discarded nonzero bits

Behaviour:
- Reset: asynchronous and active low on rst_n. On assertion, state = IDLE, in_ready = 1, out_valid = 0, out_data = 0x00000000, out_inexact = 0, and all internal registers clear.
- Reset mid-operation aborts the conversion immediately; no partial result is ever presented.
- States: IDLE, NORM, ROUND, DONE. in_ready = 1 only in IDLE. out_valid = 1 only in DONE.
- IDLE, accept when in_valid && in_ready:
  - sign = in_signed & in_data[31].
  - mag (32-bit unsigned) = sign ? -in_data : in_data, so -2^31 gives mag = 0x80000000.
  - exp = 8'd158 (EXP_BIAS + 31).
  - If mag == 0: out_data = 0x00000000 (+0, never -0), out_inexact = 0, go to DONE.
  - Otherwise go to NORM.
- NORM, one cycle per step:
  - If mag[31] = 1, go to ROUND.
  - Else mag <<= 1 and exp -= 1.
  - exp never falls below 127, so no denormals or underflow occur.
- ROUND, one cycle:
  - mant = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Round up when guard && (sticky || mant[0]).
  - If mant is all ones and rounds up: mant = 0 and exp += 1. The maximum exp is 159, so no overflow occurs.
  - Register out_data = {sign, exp, mant} and out_inexact = guard | sticky, then go to DONE.
- DONE:
  - out_data and out_inexact are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle bypass.
- Latency from the accept edge T to out_valid:
  - Zero operand: T+1.
  - Highest set bit of mag at position k: T+34-k, so best case T+3 and worst case T+34.
- Throughput: one conversion in flight at a time.
- in_data and in_signed are sampled only at accept. Later changes to them are ignored.

Decomposition:
- Shared package fp32_pkg holds:
  - the state enum (IDLE, NORM, ROUND, DONE);
  - EXP_BIAS;
  - the field positions SIGN_BIT = 31, EXP_MSB = 30, EXP_LSB = 23, MANT_MSB = 22;
  - the constant FP32_POS_ZERO = 32'h00000000.
- One combinational sub-module, fp32_round_rne: inputs mant[22:0], guard, sticky and exp[7:0]; outputs the rounded mant and exp plus the inexact flag. The floating-point arithmetic units reuse it.

Test Plan:
- in_data = 1, in_signed = 0, out_ready = 1 -> out_data = 0x3F800000, out_inexact = 0, out_valid at T+34.
- in_data = 0x80000000, in_signed = 1 -> out_data = 0xCF000000 at T+3. With in_signed = 0 -> 0x4F000000. in_data = 0xFFFFFFFF, in_signed = 1 -> 0xBF800000.
- Rounding cases:
  - 0x01000001 -> 0x4B800000, inexact = 1 (tie, rounds to even).
  - 0x01000003 -> 0x4B800002, inexact = 1 (tie, rounds up).
  - 0xFFFFFFFF unsigned -> 0x4F800000, inexact = 1 (mantissa carry into exponent).
- in_data = 0 with in_signed = 1 -> out_data = 0x00000000 at T+1.
- Back-pressure: hold out_ready = 0 for 5 cycles with in_valid held high and a new operand -> out_data stays stable and in_ready stays 0. The new operand is accepted only after the result handshake.
- Drop rst_n mid-NORM -> out_valid = 0 and in_ready = 1 immediately. After release, a fresh conversion of 7 gives 0x40E00000.
